// File: rtl/fmul_pipe_if.sv
// Handshake and data bundle for the fmul_pipe floating-point multiplier.
// The slave side is the multiplier, the master side is whoever feeds it and takes results.
interface fmul_pipe_if #(
    parameter int EW = 8,
    parameter int MW = 23
);
    localparam int W = 1 + EW + MW;

    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] x1;
    logic [W-1:0] x2;
    logic         rm;
    logic         ftz;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] y;
    logic         ovf;
    logic         unf;
    logic         nx;
    logic         nv;

    modport slave (
        input  in_valid, x1, x2, rm, ftz, out_ready,
        output in_ready, out_valid, y, ovf, unf, nx, nv
    );

    modport master (
        output in_valid, x1, x2, rm, ftz, out_ready,
        input  in_ready, out_valid, y, ovf, unf, nx, nv
    );
endinterface

// File: rtl/fmul_pipe.sv
// Three-stage IEEE-style floating-point multiplier with valid/ready flow control:
// S1 unpack and mantissa product, S2 normalise/denormalise and sticky, S3 round, pack and flags.
module fmul_pipe #(
    parameter int EW = 8,
    parameter int MW = 23
) (
    input logic        clk,
    input logic        rstn,
    fmul_pipe_if.slave bus
);
    localparam int W   = 1 + EW + MW;
    localparam int M   = MW + 1;
    localparam int PW  = 2 * M;
    localparam int XW  = EW + 2;
    localparam int LZW = $clog2(PW + 1);
    localparam logic [EW-1:0] EALL = '1;
    localparam logic [XW-1:0] BIAS = XW'((1 << (EW - 1)) - 1);

    logic adv;
    logic v1, v2, v3;

    logic          s1_sign, s1_rm, s1_ftz, s1_nan, s1_inf, s1_zero, s1_nv;
    logic [XW-1:0] s1_exp;
    logic [PW-1:0] s1_prod;

    logic          s2_sign, s2_rm, s2_ftz, s2_nan, s2_inf, s2_zero, s2_nv;
    logic          s2_tiny, s2_g, s2_r, s2_s;
    logic [EW:0]   s2_exp;
    logic [MW-1:0] s2_mant;

    logic [W-1:0]  s3_y;
    logic          s3_ovf, s3_unf, s3_nx, s3_nv;

    // The whole pipe moves as one; it stalls only when the output slot is full and not taken.
    assign adv           = !v3 || bus.out_ready;
    assign bus.in_ready  = adv;
    assign bus.out_valid = v3;
    assign bus.y         = s3_y;
    assign bus.ovf       = s3_ovf;
    assign bus.unf       = s3_unf;
    assign bus.nx        = s3_nx;
    assign bus.nv        = s3_nv;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            v1 <= 1'b0;
            v2 <= 1'b0;
            v3 <= 1'b0;
        end else if (adv) begin
            v1 <= bus.in_valid;
            v2 <= v1;
            v3 <= v2;
        end
    end

    logic [EW-1:0] e_a, e_b;
    logic [MW-1:0] f_a, f_b;
    logic [M-1:0]  m_a, m_b;
    logic [XW-1:0] ee_a, ee_b;
    logic          nan_a, nan_b, inf_a, inf_b, zero_a, zero_b, snan_a, snan_b, inv;

    // Subnormal operands get a hidden bit of 0 and behave as if their exponent were 1.
    always_comb begin
        e_a    = bus.x1[W-2:MW];
        f_a    = bus.x1[MW-1:0];
        e_b    = bus.x2[W-2:MW];
        f_b    = bus.x2[MW-1:0];
        m_a    = {|e_a, f_a};
        m_b    = {|e_b, f_b};
        ee_a   = (e_a == '0) ? XW'(1) : {2'b00, e_a};
        ee_b   = (e_b == '0) ? XW'(1) : {2'b00, e_b};
        nan_a  = (e_a == EALL) && (f_a != '0);
        nan_b  = (e_b == EALL) && (f_b != '0);
        inf_a  = (e_a == EALL) && (f_a == '0);
        inf_b  = (e_b == EALL) && (f_b == '0);
        zero_a = (e_a == '0) && (f_a == '0);
        zero_b = (e_b == '0) && (f_b == '0);
        snan_a = nan_a && !f_a[MW-1];
        snan_b = nan_b && !f_b[MW-1];
        inv    = (inf_a && zero_b) || (zero_a && inf_b);
    end

    always_ff @(posedge clk) begin
        if (adv) begin
            s1_sign <= bus.x1[W-1] ^ bus.x2[W-1];
            s1_rm   <= bus.rm;
            s1_ftz  <= bus.ftz;
            s1_nan  <= nan_a || nan_b || inv;
            s1_nv   <= snan_a || snan_b || inv;
            s1_inf  <= inf_a || inf_b;
            s1_zero <= zero_a || zero_b;
            s1_exp  <= ee_a + ee_b - BIAS + XW'(1);
            s1_prod <= PW'(m_a) * PW'(m_b);
        end
    end

    logic [LZW-1:0] lz;
    logic [PW-1:0]  norm, lost;
    logic [XW-1:0]  e_n, dsh;
    logic [PW-2:0]  r;
    logic           tiny_pre, carry_up, d_sticky;

    // Tiny results are shifted right here so rounding happens only once, at subnormal precision.
    always_comb begin
        lz = '0;
        for (int i = 0; i < PW; i++) begin
            if (s1_prod[i]) lz = LZW'(PW - 1 - i);
        end
        norm     = s1_prod << lz;
        e_n      = s1_exp - XW'(lz);
        tiny_pre = e_n[XW-1] || (e_n == '0);
        dsh      = XW'(1) - e_n;
        if (dsh > XW'(PW)) dsh = XW'(PW);
        lost     = norm & ~({PW{1'b1}} << dsh);
        r        = norm[PW-2:0];
        d_sticky = 1'b0;
        if (tiny_pre) begin
            r        = (PW-1)'(norm >> dsh);
            d_sticky = |lost;
        end
        carry_up = (e_n == '0) && (&norm[PW-2 -: MW]) && norm[MW] && !s1_rm;
    end

    always_ff @(posedge clk) begin
        if (adv) begin
            s2_sign <= s1_sign;
            s2_rm   <= s1_rm;
            s2_ftz  <= s1_ftz;
            s2_nan  <= s1_nan;
            s2_nv   <= s1_nv;
            s2_inf  <= s1_inf;
            s2_zero <= s1_zero;
            s2_exp  <= tiny_pre ? '0 : e_n[EW:0];
            s2_mant <= r[PW-2 -: MW];
            s2_g    <= r[MW];
            s2_r    <= r[MW-1];
            s2_s    <= (|r[MW-2:0]) || d_sticky;
            s2_tiny <= tiny_pre && !carry_up;
        end
    end

    logic          inc, inexact, over;
    logic [EW+MW:0] sum;
    logic [W-1:0]  y_d;
    logic          ovf_d, unf_d, nx_d, nv_d;

    // A mantissa carry ripples straight into the exponent field, which also covers subnormal-to-normal.
    always_comb begin
        inc     = !s2_rm && s2_g && (s2_r || s2_s || s2_mant[0]);
        inexact = s2_g || s2_r || s2_s;
        sum     = {s2_exp, s2_mant} + {{(EW+MW){1'b0}}, inc};
        over    = sum[EW+MW -: EW+1] >= {1'b0, EALL};
        y_d     = {s2_sign, sum[EW+MW-1:0]};
        ovf_d   = 1'b0;
        unf_d   = 1'b0;
        nx_d    = 1'b0;
        nv_d    = 1'b0;
        if (s2_nan) begin
            y_d  = {1'b0, EALL, 1'b1, {(MW-1){1'b0}}};
            nv_d = s2_nv;
        end else if (s2_inf) begin
            y_d = {s2_sign, EALL, {MW{1'b0}}};
        end else if (s2_zero) begin
            y_d = {s2_sign, {(EW+MW){1'b0}}};
        end else if (over) begin
            ovf_d = 1'b1;
            nx_d  = 1'b1;
            y_d   = s2_rm ? {s2_sign, EALL - EW'(1), {MW{1'b1}}} : {s2_sign, EALL, {MW{1'b0}}};
        end else if (s2_tiny && s2_ftz) begin
            y_d   = {s2_sign, {(EW+MW){1'b0}}};
            unf_d = 1'b1;
            nx_d  = 1'b1;
        end else begin
            nx_d  = inexact;
            unf_d = s2_tiny && inexact;
        end
    end

    always_ff @(posedge clk) begin
        if (adv) begin
            s3_y   <= y_d;
            s3_ovf <= ovf_d;
            s3_unf <= unf_d;
            s3_nx  <= nx_d;
            s3_nv  <= nv_d;
        end
    end
endmodule

// File: tb/tb_fmul_pipe.sv
// Scoreboard bench for fmul_pipe: directed vectors push expected results, a monitor pops and compares.
module tb_fmul_pipe;
    localparam int EW = 8;
    localparam int MW = 23;

    typedef struct {
        logic [31:0] y;
        logic [3:0]  fl;
        int          issued;
        bit          lat;
        int          id;
    } exp_t;

    logic clk  = 1'b0;
    logic rstn = 1'b1;
    int   cyc  = 0;
    int   errors = 0;
    int   checks = 0;
    exp_t sb[$];

    logic [31:0] bp_a [6];
    logic [31:0] bp_y [6];
    logic [5:0]  stall_mask;

    fmul_pipe_if #(.EW(EW), .MW(MW)) bus ();

    fmul_pipe #(.EW(EW), .MW(MW)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus.slave)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_output(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", nm, act, req);
        end
    endtask

    // Offer one pair, wait (bounded) for acceptance, then record what must come out.
    task automatic apply_stimulus(input logic [31:0] a, input logic [31:0] b, input logic r, input logic f,
                                  input logic [31:0] ey, input logic [3:0] ef, input bit lat,
                                  input int id, output int stalls);
        exp_t e;
        stalls = 0;
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.x1       = a;
        bus.x2       = b;
        bus.rm       = r;
        bus.ftz      = f;
        #1;
        while (!bus.in_ready && stalls < 50) begin
            @(negedge clk);
            #1;
            stalls++;
        end
        check_output($sformatf("accept[v%0d]", id), 32'(bus.in_ready), 32'd1);
        if (bus.in_ready) begin
            e.y      = ey;
            e.fl     = ef;
            e.issued = cyc;
            e.lat    = lat;
            e.id     = id;
            sb.push_back(e);
        end
        @(posedge clk);
    endtask

    task automatic idle();
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 40) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        check_output("drain", 32'(sb.size()), 32'd0);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (rstn && bus.out_valid) begin
                if (sb.size() == 0) begin
                    check_output("unexpected_output", 32'(bus.out_valid), 32'd0);
                end else begin
                    e = sb[0];
                    check_output($sformatf("y[v%0d]", e.id), bus.y, e.y);
                    check_output($sformatf("flags[v%0d]", e.id),
                                 {28'd0, bus.ovf, bus.unf, bus.nx, bus.nv}, {28'd0, e.fl});
                    if (bus.out_ready) begin
                        if (e.lat) check_output($sformatf("latency[v%0d]", e.id), 32'(cyc - e.issued), 32'd3);
                        void'(sb.pop_front());
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("[TB] FAIL watchdog: simulation did not complete");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin : main
        int st;
        bp_a = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000, 32'h40A00000, 32'h40C00000};
        bp_y = '{32'h40000000, 32'h40800000, 32'h40C00000, 32'h41000000, 32'h41200000, 32'h41400000};
        stall_mask    = '0;
        bus.in_valid  = 1'b0;
        bus.x1        = '0;
        bus.x2        = '0;
        bus.rm        = 1'b0;
        bus.ftz       = 1'b0;
        bus.out_ready = 1'b0;

        #1 rstn = 1'b0;
        #1;
        check_output("reset_out_valid", 32'(bus.out_valid), 32'd0);
        check_output("reset_in_ready", 32'(bus.in_ready), 32'd1);
        bus.out_ready = 1'b1;
        repeat (2) @(negedge clk);
        #3 rstn = 1'b1;

        // {ovf,unf,nx,nv} in the flag column
        apply_stimulus(32'h3FC00000, 32'h40000000, 0, 0, 32'h40400000, 4'b0000, 1, 0, st);
        apply_stimulus(32'h7F7FFFFF, 32'h40000000, 0, 0, 32'h7F800000, 4'b1010, 1, 1, st);
        apply_stimulus(32'h7F7FFFFF, 32'h40000000, 1, 0, 32'h7F7FFFFF, 4'b1010, 1, 2, st);
        apply_stimulus(32'h7F800000, 32'h00000000, 0, 0, 32'h7FC00000, 4'b0001, 1, 3, st);
        apply_stimulus(32'h7F800001, 32'h3F800000, 0, 0, 32'h7FC00000, 4'b0001, 1, 4, st);
        apply_stimulus(32'h00800000, 32'h3F000000, 0, 0, 32'h00400000, 4'b0000, 1, 5, st);
        apply_stimulus(32'h00800000, 32'h3F000000, 0, 1, 32'h00000000, 4'b0110, 1, 6, st);
        apply_stimulus(32'h7F800000, 32'hC0000000, 0, 0, 32'hFF800000, 4'b0000, 1, 7, st);
        apply_stimulus(32'h80000000, 32'h40A00000, 0, 0, 32'h80000000, 4'b0000, 1, 8, st);
        apply_stimulus(32'h7FC00001, 32'h3F800000, 0, 0, 32'h7FC00000, 4'b0000, 1, 9, st);
        apply_stimulus(32'h40400000, 32'h3F800001, 0, 0, 32'h40400002, 4'b0010, 1, 10, st);
        apply_stimulus(32'h40400000, 32'h3F800001, 1, 0, 32'h40400001, 4'b0010, 1, 11, st);
        apply_stimulus(32'h00000003, 32'h3F000000, 0, 0, 32'h00000002, 4'b0110, 1, 12, st);
        apply_stimulus(32'h3F800001, 32'h3F800001, 0, 0, 32'h3F800002, 4'b0010, 1, 13, st);
        idle();
        drain();

        // Consumer stalls for 5 cycles while six pairs are offered back to back.
        @(negedge clk);
        bus.out_ready = 1'b0;
        fork
            begin
                repeat (5) @(negedge clk);
                bus.out_ready = 1'b1;
            end
            begin
                int bst;
                for (int i = 0; i < 6; i++) begin
                    apply_stimulus(bp_a[i], 32'h40000000, 0, 0, bp_y[i], 4'b0000, 0, 100 + i, bst);
                    if (bst != 0) stall_mask[i] = 1'b1;
                end
            end
        join
        check_output("backpressure_stall_mask", 32'(stall_mask), 32'h08);
        idle();
        drain();

        // Two results in flight when reset hits; none of them may surface afterwards.
        apply_stimulus(32'h40000000, 32'h40400000, 0, 0, 32'h40C00000, 4'b0000, 0, 200, st);
        apply_stimulus(32'h40400000, 32'h40400000, 0, 0, 32'h41100000, 4'b0000, 0, 201, st);
        #3 rstn = 1'b0;
        #1;
        check_output("midreset_out_valid", 32'(bus.out_valid), 32'd0);
        check_output("midreset_in_ready", 32'(bus.in_ready), 32'd1);
        sb.delete();
        bus.in_valid = 1'b0;
        @(negedge clk);
        #3 rstn = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            #1;
            check_output($sformatf("post_reset_quiet[%0d]", i), 32'(bus.out_valid), 32'd0);
        end

        apply_stimulus(32'h3FC00000, 32'h40000000, 0, 0, 32'h40400000, 4'b0000, 1, 300, st);
        idle();
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/fmul_pipe.md
FMUL_PIPE -- requirements
Module: fmul_pipe

Interface
REQ-001 The block SHALL have parameter EW, default 8, meaning exponent width in bits.
REQ-002 The block SHALL have parameter MW, default 23, meaning stored mantissa width in bits; the operand width is W = 1+EW+MW.
REQ-003 The block SHALL have port clk, input, 1 bit, meaning the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rstn, input, 1 bit, meaning asynchronous active-low reset.
REQ-005 The block SHALL have port in_valid, input, 1 bit, meaning the operand pair is offered.
REQ-006 The block SHALL have port in_ready, output, 1 bit, meaning the block accepts the offered pair this cycle.
REQ-007 The block SHALL have ports x1 and x2, input, W bits each, meaning IEEE-style operands {sign, exponent, mantissa}.
REQ-008 The block SHALL have port rm, input, 1 bit, meaning rounding mode: 0 = round-to-nearest-even, 1 = round-toward-zero; sampled with the operands.
REQ-009 The block SHALL have port ftz, input, 1 bit, meaning flush subnormal results to signed zero; sampled with the operands.
REQ-010 The block SHALL have port out_valid, output, 1 bit, meaning y and flags hold a result.
REQ-011 The block SHALL have port out_ready, input, 1 bit, meaning the consumer takes the result this cycle.
REQ-012 The block SHALL have port y, output, W bits, meaning the rounded product.
REQ-013 The block SHALL have ports ovf, unf, nx and nv, outputs, 1 bit each, meaning overflow, underflow, inexact and invalid, valid while out_valid is high.

Function
REQ-014 The pipeline SHALL have three registered stages: S1 unpack/classify and mantissa product (2*(MW+1) bits), S2 leading-one normalise and sticky, S3 round, pack and flags.
REQ-015 A transfer SHALL occur on a cycle when in_valid and in_ready are both high; the output handshake completes when out_valid and out_ready are both high.
REQ-016 The signal advance SHALL equal (!out_valid || out_ready); in_ready SHALL equal advance; all stages shift only when advance is high and hold otherwise.
REQ-017 A bubble SHALL enter S1 when advance is high and in_valid is low; each stage carries a valid bit.
REQ-018 Latency SHALL be exactly 3 cycles from a transfer to out_valid when out_ready is held high, at a throughput of one result per cycle.
REQ-019 Results SHALL leave in acceptance order with none dropped or duplicated under any out_ready pattern; y and flags SHALL hold stable while out_valid is high and out_ready is low.
REQ-020 Subnormal operands SHALL be multiplied with a hidden bit of 0 and an effective exponent of 1.
REQ-021 The exponent SHALL be computed as e1+e2-bias+1-shift in a signed EW+2-bit field, where bias = 2^(EW-1)-1.
REQ-022 Rounding SHALL use guard, round and sticky bits over all discarded product bits; a mantissa carry-out SHALL increment the exponent.
REQ-023 Results below the minimum normal SHALL be denormalised before rounding, so they are rounded once.
REQ-024 When ftz=1, a subnormal or underflowing result SHALL be replaced by signed zero, with unf=1 and nx=1.
REQ-025 unf SHALL be set when ftz=0 and the result is tiny after rounding and also inexact.
REQ-026 On overflow, ovf and nx SHALL be set; the result SHALL be signed infinity when rm=0, and signed max-finite ({s, all-ones minus 1, all-ones mantissa}) when rm=1.
REQ-027 Any NaN operand, or infinity times zero, SHALL produce the canonical quiet NaN {0, all-ones exponent, 1, zeros}.
REQ-028 nv SHALL be set for infinity times zero and for any signalling-NaN operand (exponent all-ones, mantissa MSB 0, mantissa nonzero).
REQ-029 Infinity times a finite nonzero value SHALL produce signed infinity with no flags set.
REQ-030 The result sign SHALL be s1 XOR s2 for all non-NaN results, including zero results.

Reset
REQ-031 While rstn is low, all stage valid bits SHALL clear, so out_valid = 0 and in_ready = 1 immediately (asynchronously).
REQ-032 Data and flag registers SHALL NOT require reset; y and flags are don't-care while out_valid = 0.
REQ-033 Reset asserted mid-operation SHALL discard all in-flight results, with no result emitted after rstn deasserts.

Verification
REQ-034 Bench SHALL apply 0x3FC00000 x 0x40000000, rm=0, out_ready=1 -> y=0x40400000 exactly 3 cycles later, all flags 0.
REQ-035 Bench SHALL apply 0x7F7FFFFF x 0x40000000 -> rm=0: y=0x7F800000, ovf=1, nx=1; rm=1: y=0x7F7FFFFF, ovf=1, nx=1.
REQ-036 Bench SHALL apply 0x7F800000 x 0x00000000 -> y=0x7FC00000, nv=1; and 0x7F800001 x 0x3F800000 -> y=0x7FC00000, nv=1.
REQ-037 Bench SHALL apply 0x00800000 x 0x3F000000 -> ftz=0: y=0x00400000, unf=0, nx=0; ftz=1: y=0x00000000, unf=1, nx=1.
REQ-038 Bench SHALL offer 6 back-to-back pairs with out_ready low for 5 cycles -> in_ready falls once 3 results are held, and all 6 results emerge in order with none lost.
REQ-039 Bench SHALL pulse rstn low with 2 results in flight -> out_valid=0 immediately, and no stale result appears after release.
